dbus_arbiter: RTL and testbench

//   Shares the word-addressed data bus (DBus) between two masters: M0 = CPU MEM stage, M1 = DMA/debug port.

---
 rtl/dbus_arbiter.sv | 157 +++++++++++++++
 tb/tb_dbus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter. It grants at most one request per cycle (fixed
// priority or round-robin with a burst limit) and routes read data back to the issuer.
module dbus_arbiter #(
  parameter int READ_LATENCY = 1,  // 1..4
  parameter int MAX_BURST    = 4,  // 1..15
  parameter int FIXED_PRIO   = 0
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_M0Req,
  input  logic        i_M0We,
  input  logic [29:0] i_M0Addr,
  input  logic [3:0]  i_M0ByteEn,
  input  logic [31:0] i_M0Wd,
  output logic        o_M0Gnt,
  output logic        o_M0RdValid,
  output logic [31:0] o_M0Rd,
  input  logic        i_M1Req,
  input  logic        i_M1We,
  input  logic [29:0] i_M1Addr,
  input  logic [3:0]  i_M1ByteEn,
  input  logic [31:0] i_M1Wd,
  output logic        o_M1Gnt,
  output logic        o_M1RdValid,
  output logic [31:0] o_M1Rd,
  output logic [29:0] o_DBusAddr,
  output logic        o_DBusRe,
  output logic        o_DBusWe,
  output logic [3:0]  o_DBusByteEn,
  output logic [31:0] o_DBusWd,
  input  logic [31:0] i_DBusRd,
  output logic        o_Busy
);

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  master_e                 last_q, last_d;
  master_e                 winner;
  logic [3:0]              cnt_q, cnt_d;
  logic                    gnt0, gnt1, gnt_any;
  logic                    push_vld, push_id;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0] id_q, id_d;
  logic                    head_vld, head_id;

  // Arbitration. A zero count means no burst is running (after reset or an idle
  // cycle), so contention then goes to the master that did not own the bus last.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    winner = M0;
    if (!i_Rst) begin
      if (i_M0Req && i_M1Req) begin
        if (FIXED_PRIO != 0)                          winner = M0;
        else if (cnt_q != 4'd0 && cnt_q < BURST_MAX)  winner = last_q;
        else                                          winner = (last_q == M0) ? M1 : M0;
        gnt0 = (winner == M0);
        gnt1 = (winner == M1);
      end else begin
        gnt0   = i_M0Req;
        gnt1   = i_M1Req;
        winner = i_M1Req ? M1 : M0;
      end
    end
  end

  assign gnt_any = gnt0 | gnt1;
  assign o_M0Gnt = gnt0;
  assign o_M1Gnt = gnt1;

  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (gnt_any) begin
      if (winner == last_q) begin
        cnt_d = (cnt_q >= BURST_MAX) ? BURST_MAX : cnt_q + 4'd1;
      end else begin
        last_d = winner;
        cnt_d  = 4'd1;
      end
    end else begin
      cnt_d = 4'd0;
    end
  end

  always_comb begin
    o_DBusAddr   = '0;
    o_DBusRe     = 1'b0;
    o_DBusWe     = 1'b0;
    o_DBusByteEn = '0;
    o_DBusWd     = '0;
    if (gnt0) begin
      o_DBusAddr   = i_M0Addr;
      o_DBusRe     = ~i_M0We;
      o_DBusWe     = i_M0We;
      o_DBusByteEn = i_M0ByteEn;
      o_DBusWd     = i_M0Wd;
    end else if (gnt1) begin
      o_DBusAddr   = i_M1Addr;
      o_DBusRe     = ~i_M1We;
      o_DBusWe     = i_M1We;
      o_DBusByteEn = i_M1ByteEn;
      o_DBusWd     = i_M1Wd;
    end
  end

  // Read-tag pipeline: the tag reaches the head in the cycle its data is on i_DBusRd.
  assign push_vld = o_DBusRe;
  assign push_id  = gnt1;

  always_comb begin
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = push_vld;
    id_d[0]  = push_id;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      last_q <= M1;
      cnt_q  <= 4'd0;
      vld_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  // NOTE: tag ids are left unreset on purpose; they are meaningless unless the valid bit is set.
  always_ff @(posedge i_Clk) begin
    id_q <= id_d;
  end

  assign head_vld = vld_q[READ_LATENCY-1] & ~i_Rst;
  assign head_id  = id_q[READ_LATENCY-1];

  always_comb begin
    o_M0RdValid = head_vld & ~head_id;
    o_M1RdValid = head_vld & head_id;
    o_M0Rd      = o_M0RdValid ? i_DBusRd : '0;
    o_M1Rd      = o_M1RdValid ? i_DBusRd : '0;
    o_Busy      = (|vld_q) & ~i_Rst;
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized and directed bench for dbus_arbiter. It runs two configurations side by
// side (round-robin with latency 3, and fixed priority with latency 1).
module tb_dbus_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } mreq_t;

  typedef struct {
    int inst;
    int due;
    int id;
  } ret_t;

  logic        clk = 1'b0;
  logic        rst;
  mreq_t       mi     [2][2];
  logic [31:0] bus_rd [2];
  logic        gnt    [2][2];
  logic        rdv    [2][2];
  logic [31:0] rd     [2][2];
  logic [29:0] daddr  [2];
  logic        dre    [2];
  logic        dwe    [2];
  logic [3:0]  dbe    [2];
  logic [31:0] dwd    [2];
  logic        busy   [2];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          last_m[2];
  int          cnt_m [2];
  int          win_m [2];
  ret_t        rq[$];
  bit          rd_forced = 1'b0;
  logic [31:0] rd_force  = '0;

  always #5 clk = ~clk;

  function automatic int lat_of(int k);
    return (k == 0) ? 3 : 1;
  endfunction
  function automatic int burst_of(int k);
    return (k == 0) ? 4 : 3;
  endfunction
  function automatic bit fixed_of(int k);
    return (k != 0);
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    dbus_arbiter #(
      .READ_LATENCY(k == 0 ? 3 : 1),
      .MAX_BURST   (k == 0 ? 4 : 3),
      .FIXED_PRIO  (k == 0 ? 0 : 1)
    ) u_dut (
      .i_Clk       (clk),
      .i_Rst       (rst),
      .i_M0Req     (mi[k][0].req),
      .i_M0We      (mi[k][0].we),
      .i_M0Addr    (mi[k][0].addr),
      .i_M0ByteEn  (mi[k][0].be),
      .i_M0Wd      (mi[k][0].wd),
      .o_M0Gnt     (gnt[k][0]),
      .o_M0RdValid (rdv[k][0]),
      .o_M0Rd      (rd[k][0]),
      .i_M1Req     (mi[k][1].req),
      .i_M1We      (mi[k][1].we),
      .i_M1Addr    (mi[k][1].addr),
      .i_M1ByteEn  (mi[k][1].be),
      .i_M1Wd      (mi[k][1].wd),
      .o_M1Gnt     (gnt[k][1]),
      .o_M1RdValid (rdv[k][1]),
      .o_M1Rd      (rd[k][1]),
      .o_DBusAddr  (daddr[k]),
      .o_DBusRe    (dre[k]),
      .o_DBusWe    (dwe[k]),
      .o_DBusByteEn(dbe[k]),
      .o_DBusWd    (dwd[k]),
      .i_DBusRd    (bus_rd[k]),
      .o_Busy      (busy[k])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_m(input int m, input bit req, input bit we, input logic [29:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    for (int k = 0; k < 2; k++) begin
      mi[k][m].req  = req;
      mi[k][m].we   = we;
      mi[k][m].addr = addr;
      mi[k][m].be   = be;
      mi[k][m].wd   = wd;
    end
  endtask

  task automatic idle();
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One cycle: drive read data, check every output against the model, advance the model.
  task automatic step();
    for (int k = 0; k < 2; k++) bus_rd[k] = rd_forced ? rd_force : $urandom;
    #1;
    for (int k = 0; k < 2; k++) begin
      int          w;
      int          rid;
      bit          r0, r1, bsy;
      logic [67:0] eb;
      ret_t        e;
      r0  = mi[k][0].req;
      r1  = mi[k][1].req;
      w   = -1;
      rid = -1;
      bsy = 1'b0;
      if (!rst) begin
        if (r0 && r1) begin
          if (fixed_of(k))                                     w = 0;
          else if (cnt_m[k] > 0 && cnt_m[k] < burst_of(k))     w = last_m[k];
          else                                                 w = 1 - last_m[k];
        end else if (r0) w = 0;
        else if (r1)     w = 1;
      end
      eb = '0;
      if (w >= 0)
        eb = {mi[k][w].addr, !mi[k][w].we, mi[k][w].we, mi[k][w].be, mi[k][w].wd};
      if (!rst) begin
        foreach (rq[i]) begin
          if (rq[i].inst == k) begin
            bsy = 1'b1;
            if (rq[i].due == cyc) rid = rq[i].id;
          end
        end
      end
      check($sformatf("i%0d_gnt0", k), 128'(gnt[k][0]), 128'(w == 0));
      check($sformatf("i%0d_gnt1", k), 128'(gnt[k][1]), 128'(w == 1));
      check($sformatf("i%0d_dbus", k), 128'({daddr[k], dre[k], dwe[k], dbe[k], dwd[k]}), 128'(eb));
      check($sformatf("i%0d_rdv0", k), 128'(rdv[k][0]), 128'(rid == 0));
      check($sformatf("i%0d_rd0", k),  128'(rd[k][0]),  128'((rid == 0) ? bus_rd[k] : 32'd0));
      check($sformatf("i%0d_rdv1", k), 128'(rdv[k][1]), 128'(rid == 1));
      check($sformatf("i%0d_rd1", k),  128'(rd[k][1]),  128'((rid == 1) ? bus_rd[k] : 32'd0));
      check($sformatf("i%0d_busy", k), 128'(busy[k]),   128'(bsy));
      win_m[k] = w;
      if (rst) begin
        last_m[k] = 1;
        cnt_m[k]  = 0;
        for (int i = rq.size() - 1; i >= 0; i--)
          if (rq[i].inst == k) rq.delete(i);
      end else if (w < 0) begin
        cnt_m[k] = 0;
      end else begin
        if (w == last_m[k]) begin
          cnt_m[k] = (cnt_m[k] + 1 > burst_of(k)) ? burst_of(k) : cnt_m[k] + 1;
        end else begin
          last_m[k] = w;
          cnt_m[k]  = 1;
        end
        if (!mi[k][w].we) begin
          e.inst = k;
          e.due  = cyc + lat_of(k);
          e.id   = w;
          rq.push_back(e);
        end
      end
    end
    for (int i = rq.size() - 1; i >= 0; i--)
      if (rq[i].due <= cyc) rq.delete(i);
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int k = 0; k < 2; k++) begin
      last_m[k] = 1;
      cnt_m[k]  = 0;
      win_m[k]  = -1;
    end
    repeat (2) begin
      @(negedge clk);
      step();
    end

    // Lone M0 read, data returned after each instance's latency.
    @(negedge clk);
    rst       = 1'b0;
    rd_forced = 1'b1;
    rd_force  = 32'hDEADBEEF;
    set_m(0, 1'b1, 1'b0, 30'h10, 4'hF, 32'h0);
    step();
    check("t1_addr", 128'(daddr[0]), 128'(30'h10));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      idle();
      step();
      if (j == 0) check("t1_rd_lat1", 128'(rd[1][0]), 128'(32'hDEADBEEF));
      if (j == 2) check("t1_rd_lat3", 128'(rd[0][0]), 128'(32'hDEADBEEF));
    end
    rd_forced = 1'b0;

    // Both masters hold reads: round-robin bursts of 4 vs fixed priority.
    @(negedge clk);
    rst = 1'b1;
    set_m(0, 1'b1, 1'b0, 30'h100, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b0, 30'h200, 4'hF, 32'h0);
    step();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      step();
      check("t2_rr_seq", 128'(gnt[0][1]), 128'((i / 4) % 2));
      check("t2_fp_m0", 128'(gnt[1][0]), 128'(1));
    end
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    step();
    check("t3_m1_after_drop", 128'(gnt[1][1]), 128'(1));

    // Alternating back-to-back reads, returned in order on consecutive cycles.
    @(negedge clk);
    rst = 1'b1;
    idle();
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0;
      idle();
      set_m(i % 2, 1'b1, 1'b0, 30'(i + 1), 4'hF, 32'h0);
      step();
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      idle();
      step();
      if (j < 3) begin
        check("t4_order", 128'(rdv[0][j % 2]), 128'(1));
        check("t4_busy", 128'(busy[0]), 128'(1));
      end
    end

    // M1 write.
    @(negedge clk);
    set_m(1, 1'b1, 1'b1, 30'h20, 4'b0011, 32'h1234);
    step();
    check("t5_we", 128'(dwe[0]), 128'(1));
    check("t5_be", 128'(dbe[0]), 128'(4'b0011));
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      idle();
      step();
    end

    // Reset right after an M1 read grant; next contention goes to M0.
    @(negedge clk);
    set_m(1, 1'b1, 1'b0, 30'h40, 4'hF, 32'h0);
    step();
    @(negedge clk);
    rst = 1'b1;
    set_m(0, 1'b1, 1'b0, 30'h50, 4'hF, 32'h0);
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    check("t6_rr_m0", 128'(gnt[0][0]), 128'(1));
    check("t6_fp_m0", 128'(gnt[1][0]), 128'(1));
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      idle();
      step();
    end

    // Random traffic; a request is held with stable fields until it is granted.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int m = 0; m < 2; m++) begin
          if (!(mi[k][m].req && win_m[k] != m)) begin
            mi[k][m].req  = ($urandom_range(0, 9) < 6);
            mi[k][m].we   = 1'($urandom_range(0, 1));
            mi[k][m].addr = 30'($urandom);
            mi[k][m].be   = 4'($urandom);
            mi[k][m].wd   = $urandom;
          end
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
